// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
//
// Computes the low XLEN bits of op_a*op_b by shift-and-add, borrowing the
// shared execute-stage ALU for every addition. After a request is accepted
// the sequencer drives the ALU inputs and control. The product is then
// offered on a valid/ready result port.
//
// Ports
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   start_valid/start_ready  request handshake (ready only in IDLE)
//   op_a, op_b               multiplicand / multiplier, sampled on accept
//   res_valid/res_ready      result handshake (valid only in DONE)
//   result                   accumulator (meaningful while res_valid)
//   busy                     high in RUN or DONE
//   alu_input1/2, alu_control  to the shared ALU (ADD while running)
//   alu_result               combinational sum returned by the ALU
module alu_mul_sequencer #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [XLEN-1:0] alu_input1,
  output logic [XLEN-1:0] alu_input2,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [XLEN-1:0]   acc_reg, acc_next;
  logic [XLEN-1:0]   mcand_reg, mcand_next;
  logic [XLEN-1:0]   mplier_reg, mplier_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    cnt_next    = cnt_reg;

    unique case (state_reg)
      IDLE: begin
        if (start_valid) begin
          mcand_next  = op_a;
          mplier_next = op_b;
          acc_next    = '0;
          cnt_next    = '0;
          state_next  = RUN;
        end
      end

      RUN: begin
        if (mplier_reg[0]) begin
          acc_next = alu_result;
        end
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Stop early once no set multiplier bits remain above the current one;
        // the remaining iterations would only add zero.
        if ((cnt_reg == CNT_LAST) || ((mplier_reg >> 1) == '0)) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake/status outputs decode from state alone so no input reaches them
  // combinationally.
  assign start_ready = (state_reg == IDLE);
  assign res_valid   = (state_reg == DONE);
  assign busy        = (state_reg == RUN) || (state_reg == DONE);
  assign result      = acc_reg;

  // The ALU is only driven with live operands while iterating; otherwise the
  // inputs are parked at zero so the shared ALU sees a quiet ADD.
  assign alu_input1  = (state_reg == RUN) ? acc_reg   : '0;
  assign alu_input2  = (state_reg == RUN) ? mcand_reg : '0;
  assign alu_control = ALU_ADD;

endmodule
